// File: rtl/weight_buffer_pkg.sv
// weight_buffer shared parameters and types.
// Lane-to-bank mapping helper for the kernel gather.
package weight_buffer_pkg;

  localparam int X_PE       = 16;
  localparam int X_MESH     = 16;
  localparam int ADDR_LEN   = 9;
  localparam int DATA_LEN   = 64;
  localparam int RAM_DEPTH  = 2 ** ADDR_LEN;
  localparam int LANES      = X_PE * X_MESH;
  localparam int BUFFER_NUM = 8 * LANES / DATA_LEN;
  localparam int KER_TAPS   = 9;
  localparam int LANE_W     = KER_TAPS * 8;
  localparam int KER_W      = LANES * LANE_W;
  localparam int BEAT_W     = $clog2(BUFFER_NUM);
  localparam int TAP_W      = 4;

  typedef struct packed {
    logic [BEAT_W-1:0] bank;
    logic [2:0]        byte_sel;
  } lane_loc_t;

  function automatic lane_loc_t lane_loc(input int n);
    lane_loc_t l;
    l.bank     = BEAT_W'(n / 8);
    l.byte_sel = 3'(n % 8);
    return l;
  endfunction

endpackage

// File: rtl/weight_buffer_if.sv
// weight_buffer write-stream and kernel-read bundle.
// master = loader/PE side, slave = buffer.
interface weight_buffer_if;
  import weight_buffer_pkg::*;

  logic [DATA_LEN-1:0] data_wr;
  logic [ADDR_LEN-1:0] st_wr_addr;
  logic                wr_en;
  logic                wr_ready;
  logic [ADDR_LEN-1:0] st_rd_addr;
  logic                rd_conf;
  logic                rd_ready;
  logic                ker_en;
  logic [KER_W-1:0]    ker_out;

  modport master (
    output data_wr,
    output st_wr_addr,
    output wr_en,
    output st_rd_addr,
    output rd_conf,
    input  wr_ready,
    input  rd_ready,
    input  ker_en,
    input  ker_out
  );

  modport slave (
    input  data_wr,
    input  st_wr_addr,
    input  wr_en,
    input  st_rd_addr,
    input  rd_conf,
    output wr_ready,
    output rd_ready,
    output ker_en,
    output ker_out
  );

endinterface

// File: rtl/weight_buffer_bank.sv
// Simple dual-port weight RAM bank.
// Registered read, read-first on address collision.
module weight_bank #(
  parameter int AW = 9,
  parameter int DW = 64
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata;

  // write port and read port share one edge; read sees the old word
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/weight_buffer.sv
// weight_buffer: banked weight store with 3x3 kernel gather.
// Write beats stripe across banks; a read gathers 9 rows.
module weight_buffer
  import weight_buffer_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  weight_buffer_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [TAP_W-1:0] LAST_ISSUE = TAP_W'(KER_TAPS - 1);
  localparam logic [TAP_W-1:0] LAST_CAP   = TAP_W'(KER_TAPS);
  localparam logic [TAP_W-1:0] LAST_CNT   = TAP_W'(KER_TAPS + 1);

  logic [1:0]          r_state;
  logic [TAP_W-1:0]    r_cnt;
  logic [ADDR_LEN-1:0] r_base;
  logic [BEAT_W-1:0]   r_beat;
  logic [ADDR_LEN-1:0] r_wr_row;
  logic [KER_W-1:0]    r_ker;

  logic                w_beat;
  logic [ADDR_LEN-1:0] w_wr_row;
  logic                w_accept;
  logic                w_issue;
  logic                w_cap;
  logic [TAP_W-1:0]    w_tap;
  logic [ADDR_LEN-1:0] w_rd_addr;
  logic [BUFFER_NUM-1:0] w_we;
  logic [DATA_LEN-1:0] w_rdata [BUFFER_NUM];
  logic [7:0]          w_lane_byte [LANES];

  assign w_beat   = bus.wr_en;
  assign w_wr_row = (r_beat == '0) ? bus.st_wr_addr : r_wr_row;

  assign w_accept = bus.rd_conf &&
                    ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_issue  = (r_state == S_READ) && (r_cnt <= LAST_ISSUE);
  assign w_cap    = (r_state == S_READ) && (r_cnt != '0) &&
                    (r_cnt <= LAST_CAP);
  assign w_tap    = r_cnt - TAP_W'(1);
  assign w_rd_addr = r_base + ADDR_LEN'(r_cnt);

  // one-hot bank select for the current write beat
  always_comb begin
    w_we = '0;
    for (int b = 0; b < BUFFER_NUM; b++) begin
      w_we[b] = w_beat && (r_beat == BEAT_W'(b));
    end
  end

  for (genvar b = 0; b < BUFFER_NUM; b++) begin : g_bank
    weight_bank #(
      .AW (ADDR_LEN),
      .DW (DATA_LEN)
    ) u_bank (
      .i_clk   (clk),
      .i_we    (w_we[b]),
      .i_waddr (w_wr_row),
      .i_wdata (bus.data_wr),
      .i_re    (w_issue),
      .i_raddr (w_rd_addr),
      .o_rdata (w_rdata[b])
    );
  end

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    localparam lane_loc_t L = lane_loc(n);
    assign w_lane_byte[n] =
      w_rdata[L.bank][int'(L.byte_sel)*8 +: 8];
  end

  // write beat counter; beat 0 latches the burst row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat   <= '0;
      r_wr_row <= '0;
    end else if (w_beat) begin
      r_beat <= r_beat + 1'b1;
      if (r_beat == '0) begin
        r_wr_row <= bus.st_wr_addr;
      end
    end
  end

  // read FSM: issue 9 rows, drain the last capture, flag done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_base  <= '0;
    end else begin
      unique case (1'b1)
        (r_state == S_READ): begin
          r_cnt <= r_cnt + TAP_W'(1);
          if (r_cnt == LAST_CNT) begin
            r_state <= S_DONE;
          end
        end
        (r_state == S_IDLE),
        (r_state == S_DONE): begin
          if (w_accept) begin
            r_state <= S_READ;
            r_base  <= bus.st_rd_addr;
            r_cnt   <= '0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // capture one tap per cycle into every lane
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ker <= '0;
    end else if (w_cap) begin
      for (int n = 0; n < LANES; n++) begin
        for (int k = 0; k < KER_TAPS; k++) begin
          if (w_tap == TAP_W'(k)) begin
            r_ker[n*LANE_W + k*8 +: 8] <= w_lane_byte[n];
          end
        end
      end
    end
  end

  assign bus.wr_ready = 1'b1;
  assign bus.rd_ready = (r_state == S_IDLE) || (r_state == S_DONE);
  assign bus.ker_en   = (r_state == S_DONE);
  assign bus.ker_out  = r_ker;

endmodule

// File: tb/tb_weight_buffer.sv
// weight_buffer bench: memory-level model plus directed reads.
// Literal byte expectations pin the model.
module tb_weight_buffer;
  import weight_buffer_pkg::*;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  weight_buffer_if bus();

  weight_buffer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] pat(input int b, input int a);
    logic [63:0] w;
    for (int m = 0; m < 8; m++) begin
      w[m*8 +: 8] = 8'((b * 8 + m) ^ (a & 255));
    end
    w[7:0]   = 8'(b);
    w[15:8]  = 8'(a);
    w[23:16] = 8'(a >> 8);
    return w;
  endfunction

  for (genvar b = 0; b < BUFFER_NUM; b++) begin : g_pre
    initial begin
      for (int a = 0; a < RAM_DEPTH; a++) begin
        dut.g_bank[b].u_bank.r_mem[a] <= pat(b, a);
      end
    end
  end

  logic [63:0]      mem_m [BUFFER_NUM][RAM_DEPTH];
  logic [63:0]      snap  [KER_TAPS][BUFFER_NUM];
  logic [KER_W-1:0] m_ker;
  logic             m_act;
  logic             m_done;
  int               m_c;
  int               m_base;
  int               m_wbeat;
  int               m_wrow;

  initial begin
    for (int b = 0; b < BUFFER_NUM; b++) begin
      for (int a = 0; a < RAM_DEPTH; a++) begin
        mem_m[b][a] <= pat(b, a);
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ker   <= '0;
      m_act   <= 1'b0;
      m_done  <= 1'b0;
      m_c     <= 0;
      m_base  <= 0;
      m_wbeat <= 0;
      m_wrow  <= 0;
    end else begin
      if (bus.wr_en) begin
        if (m_wbeat == 0) begin
          mem_m[0][bus.st_wr_addr] <= bus.data_wr;
          m_wrow <= int'(bus.st_wr_addr);
        end else begin
          mem_m[m_wbeat][m_wrow] <= bus.data_wr;
        end
        m_wbeat <= (m_wbeat + 1) % BUFFER_NUM;
      end
      m_done <= m_act && (m_c == 11);
      if (m_act) begin
        if (m_c >= 1 && m_c <= 9) begin
          for (int b = 0; b < BUFFER_NUM; b++) begin
            snap[m_c-1][b] <= mem_m[b][(m_base + m_c - 1) % RAM_DEPTH];
          end
        end
        if (m_c >= 2 && m_c <= 10) begin
          for (int n = 0; n < LANES; n++) begin
            m_ker[n*72 + (m_c-2)*8 +: 8] <=
              snap[m_c-2][n/8][(n%8)*8 +: 8];
          end
        end
        if (m_c == 11) m_act <= 1'b0;
        else m_c <= m_c + 1;
      end else if (bus.rd_conf) begin
        m_act  <= 1'b1;
        m_c    <= 1;
        m_base <= int'(bus.st_rd_addr);
      end
    end
  end

  task automatic chk(input string nm, input longint got,
                     input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  function automatic int kb(input int n, input int k);
    return int'(bus.ker_out[n*72 + k*8 +: 8]);
  endfunction

  // per-cycle comparison against the model
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        chk("rd_ready", longint'(bus.rd_ready), longint'(!m_act));
        chk("ker_en", longint'(bus.ker_en), longint'(m_done));
        chk("wr_ready", longint'(bus.wr_ready), 1);
        n_chk++;
        if (bus.ker_out !== m_ker) begin
          n_err++;
          begin : find
            for (int n = 0; n < LANES; n++) begin
              for (int k = 0; k < KER_TAPS; k++) begin
                if (bus.ker_out[n*72+k*8 +: 8] !==
                    m_ker[n*72+k*8 +: 8]) begin
                  $display("FAIL ker_out lane=%0d tap=%0d got=%0d exp=%0d",
                           n, k, bus.ker_out[n*72+k*8 +: 8],
                           m_ker[n*72+k*8 +: 8]);
                  disable find;
                end
              end
            end
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic rd_cmd(input int addr);
    @(negedge clk);
    bus.st_rd_addr = 9'(addr);
    bus.rd_conf    = 1'b1;
    @(negedge clk);
    bus.rd_conf    = 1'b0;
  endtask

  task automatic wait_ker(input int start, output int got);
    got = 0;
    for (int c = start; c < start + 20; c++) begin
      @(posedge clk);
      #1;
      if (bus.ker_en) begin
        got = c;
        break;
      end
    end
  endtask

  task automatic burst(input int row, input int v0);
    for (int i = 0; i < BUFFER_NUM; i++) begin
      if (i == 16) begin
        @(negedge clk);
        bus.wr_en = 1'b0;
      end
      @(negedge clk);
      bus.wr_en      = 1'b1;
      bus.st_wr_addr = (i == 0) ? 9'(row) : 9'h1FF;
      bus.data_wr    = {8{8'(v0 + i)}};
    end
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  int got;
  int seen;

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.data_wr    = '0;
    bus.st_wr_addr = '0;
    bus.wr_en      = 1'b0;
    bus.st_rd_addr = '0;
    bus.rd_conf    = 1'b0;
    #20;
    chk("rst_ker_out_zero", longint'(bus.ker_out == '0), 1);
    chk("rst_ker_en", longint'(bus.ker_en), 0);
    chk("rst_rd_ready", longint'(bus.rd_ready), 1);
    chk("rst_wr_ready", longint'(bus.wr_ready), 1);
    rst_n = 1'b1;

    rd_cmd(0);
    wait_ker(1, got);
    chk("pre_latency", got, 11);
    chk("pre_l0_t0", kb(0, 0), 0);
    chk("pre_l200_t0", kb(200, 0), 25);
    chk("pre_l1_t2", kb(1, 2), 2);
    chk("pre_l19_t1", kb(19, 1), 18);
    chk("pre_l255_t8", kb(255, 8), 247);

    burst(5, 0);
    rd_cmd(5);
    wait_ker(1, got);
    chk("wr_latency", got, 11);
    chk("wr_l255_t0", kb(255, 0), 31);
    chk("wr_l8_t0", kb(8, 0), 1);
    chk("wr_l9_t1", kb(9, 1), 6);
    chk("wr_l251_t8", kb(251, 8), 246);

    rd_cmd(508);
    wait_ker(1, got);
    chk("wrap_latency", got, 11);
    chk("wrap_l10_t0", kb(10, 0), 1);
    chk("wrap_l9_t3", kb(9, 3), 255);
    chk("wrap_l11_t4", kb(11, 4), 11);

    rd_cmd(20);
    @(negedge clk);
    bus.st_rd_addr = 9'd100;
    bus.rd_conf    = 1'b1;
    @(negedge clk);
    bus.rd_conf    = 1'b0;
    wait_ker(3, got);
    chk("busy_latency", got, 11);
    chk("busy_l1_t0", kb(1, 0), 20);
    @(negedge clk);
    bus.st_rd_addr = 9'd40;
    bus.rd_conf    = 1'b1;
    @(negedge clk);
    bus.rd_conf    = 1'b0;
    wait_ker(1, got);
    chk("b2b_latency", got, 11);
    chk("b2b_l1_t1", kb(1, 1), 41);

    rd_cmd(0);
    fork
      begin
        repeat (2) @(negedge clk);
        burst(3, 'hA0);
      end
      wait_ker(1, got);
    join
    chk("coll_latency", got, 11);
    chk("coll_l0_t3_old", kb(0, 3), 0);
    chk("coll_l1_t3_old", kb(1, 3), 3);
    rd_cmd(3);
    wait_ker(1, got);
    chk("coll_new_l0_t0", kb(0, 0), 'hA0);
    chk("coll_new_l15_t0", kb(15, 0), 'hA1);

    rd_cmd(40);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ker_out_zero", longint'(bus.ker_out == '0), 1);
    chk("abort_ker_en", longint'(bus.ker_en), 0);
    chk("abort_rd_ready", longint'(bus.rd_ready), 1);
    chk("abort_wr_ready", longint'(bus.wr_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (bus.ker_en) seen = 1;
    end
    chk("abort_no_ker_en", seen, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
